// File: rtl/pipe_reg_chain.sv
// Fixed-depth register pipeline with per-stage valid bits, global stall, per-stage flush,
// and a RUN/DRAIN/HALTED controller that stops intake and reports when the pipe has emptied.
module pipe_reg_chain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush_mask,
    input  logic             halt_req,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_valid,
    output logic [OCC_W-1:0] occupancy,
    output logic             halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0]   data_q, data_d;
    logic [OCC_W-1:0]              occ_q, occ_d;

    logic                          accept;
    logic [DEPTH-1:0]              adv_valid;
    logic [DEPTH-1:0][WIDTH-1:0]   adv_data;

    assign in_ready = (state_q == RUN) && !stall;
    assign accept   = in_valid && in_ready;

    // Contents each stage would take on an advancing edge; stage 0 takes a bubble unless accepting.
    assign adv_valid[0] = accept;
    assign adv_data[0]  = accept ? in_data : '0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign adv_valid[gi] = valid_q[gi-1];
            assign adv_data[gi]  = data_q[gi-1];
        end
    endgenerate

    // Flush is applied last so it overrides both the shift-in and a stall hold.
    always_comb begin
        valid_d = stall ? valid_q : adv_valid;
        data_d  = stall ? data_q  : adv_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_mask[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // DRAIN exits on the pre-edge view of the stages, so HALTED lands one edge after they read empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_req) state_d = DRAIN;
            DRAIN:   if (valid_q == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign out_valid   = valid_q[DEPTH-1];
    assign out_data    = data_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign occupancy   = occ_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a DEPTH=4/WIDTH=16 instance for the main scenarios and a
// DEPTH=1/WIDTH=8 instance for the single-stage case; expected values are worked out by hand.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, halt_req;
    logic [15:0] in_data;
    logic [3:0]  flush_mask;
    logic        in_ready, out_valid, halted;
    logic [15:0] out_data;
    logic [3:0]  stage_valid;
    logic [2:0]  occupancy;

    logic        in_valid1, stall1, halt_req1;
    logic [7:0]  in_data1;
    logic [0:0]  flush_mask1;
    logic        in_ready1, out_valid1, halted1;
    logic [7:0]  out_data1;
    logic [0:0]  stage_valid1;
    logic [0:0]  occupancy1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .flush_mask(flush_mask), .halt_req(halt_req), .out_valid(out_valid),
        .out_data(out_data), .stage_valid(stage_valid), .occupancy(occupancy), .halted(halted)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .stall(stall1), .flush_mask(flush_mask1), .halt_req(halt_req1), .out_valid(out_valid1),
        .out_data(out_data1), .stage_valid(stage_valid1), .occupancy(occupancy1), .halted(halted1)
    );

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t in_v=%b in_d=%h stall=%b flush=%b halt_req=%b | out_v=%b out_d=%h sv=%b occ=%0d halted=%b",
                 $time, in_valid, in_data, stall, flush_mask, halt_req,
                 out_valid, out_data, stage_valid, occupancy, halted);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (stage_valid !== 4'b0000) begin errors++; $display("FAIL rst_sv got %b want 0000", stage_valid); end
        vectors++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL rst_out got %b/%h want 0/0000", out_valid, out_data); end
        vectors++;
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        vectors++;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_d1_out got %b want 0", out_valid1); end
        vectors++;
        rst = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        vectors++;
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_data = 16'h1111; step();
        in_data = 16'h2222; step();
        in_data = 16'h3333; step();
        if (stage_valid !== 4'b0111 || occupancy !== 3'd3) begin errors++; $display("FAIL lat_fill got %b/%0d want 0111/3", stage_valid, occupancy); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", out_valid); end
        vectors++;
        in_valid = 1'b0; in_data = 16'h0; step();
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin errors++; $display("FAIL lat_out0 got %b/%h want 1/1111", out_valid, out_data); end
        vectors++;
        step();
        if (out_valid !== 1'b1 || out_data !== 16'h2222) begin errors++; $display("FAIL lat_out1 got %b/%h want 1/2222", out_valid, out_data); end
        vectors++;
        step();
        if (out_valid !== 1'b1 || out_data !== 16'h3333) begin errors++; $display("FAIL lat_out2 got %b/%h want 1/3333", out_valid, out_data); end
        vectors++;
        step();
        if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL lat_empty got %b/%0d want 0/0", out_valid, occupancy); end
        vectors++;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 16'hAAAA; step();
        in_valid = 1'b0; in_data = 16'h0; step();
        if (stage_valid !== 4'b0010) begin errors++; $display("FAIL stall_setup got %b want 0010", stage_valid); end
        vectors++;
        stall = 1'b1; in_valid = 1'b1; in_data = 16'hBBBB;
        #1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
        vectors++;
        for (int c = 0; c < 3; c++) begin
            step();
            if (stage_valid !== 4'b0010 || occupancy !== 3'd1) begin
                errors++; $display("FAIL stall_hold%0d got %b/%0d want 0010/1", c, stage_valid, occupancy);
            end
            vectors++;
        end
        stall = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        step();
        if (stage_valid !== 4'b0100) begin errors++; $display("FAIL stall_resume got %b want 0100", stage_valid); end
        vectors++;
        step();
        if (out_valid !== 1'b1 || out_data !== 16'hAAAA) begin errors++; $display("FAIL stall_out got %b/%h want 1/aaaa", out_valid, out_data); end
        vectors++;
        step();
        if (stage_valid !== 4'b0000) begin errors++; $display("FAIL stall_empty got %b want 0000", stage_valid); end
        vectors++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 16'(k);
            step();
        end
        if (stage_valid !== 4'b1111 || occupancy !== 3'd4 || out_data !== 16'h0001) begin
            errors++; $display("FAIL flush_fill got %b/%0d/%h want 1111/4/0001", stage_valid, occupancy, out_data);
        end
        vectors++;
        in_data = 16'h0005; flush_mask = 4'b0011; step();
        if (stage_valid !== 4'b1100 || occupancy !== 3'd2) begin errors++; $display("FAIL flush_adv got %b/%0d want 1100/2", stage_valid, occupancy); end
        vectors++;
        if (out_data !== 16'h0002) begin errors++; $display("FAIL flush_adv_out got %h want 0002", out_data); end
        vectors++;
        flush_mask = 4'b0000;
        for (int k = 6; k <= 9; k++) begin
            in_data = 16'(k);
            step();
        end
        if (stage_valid !== 4'b1111 || out_data !== 16'h0006) begin errors++; $display("FAIL flush_refill got %b/%h want 1111/0006", stage_valid, out_data); end
        vectors++;
        stall = 1'b1; in_data = 16'h000A; flush_mask = 4'b0011; step();
        if (stage_valid !== 4'b1100 || occupancy !== 3'd2 || out_data !== 16'h0006) begin
            errors++; $display("FAIL flush_stall got %b/%0d/%h want 1100/2/0006", stage_valid, occupancy, out_data);
        end
        vectors++;
        stall = 1'b0; in_valid = 1'b0; in_data = 16'h0; flush_mask = 4'b0000;
        step();
        if (stage_valid !== 4'b1000 || out_data !== 16'h0007) begin errors++; $display("FAIL flush_shift got %b/%h want 1000/0007", stage_valid, out_data); end
        vectors++;
        step();
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || stage_valid !== 4'b0000) begin
            errors++; $display("FAIL flush_zero_data got %b/%h/%b want 0/0000/0000", out_valid, out_data, stage_valid);
        end
        vectors++;
    endtask

    task automatic test_halt();
        logic [15:0] exp_out [4];
        logic [3:0]  exp_sv  [4];
        exp_out[0] = 16'h0020; exp_out[1] = 16'h0030; exp_out[2] = 16'h0040;
        exp_sv[0]  = 4'b1110;  exp_sv[1]  = 4'b1100;  exp_sv[2]  = 4'b1000;
        in_valid = 1'b1;
        in_data = 16'h0010; step();
        in_data = 16'h0020; step();
        in_data = 16'h0030; step();
        halt_req = 1'b1; in_data = 16'h0040; step();
        if (stage_valid !== 4'b1111 || out_data !== 16'h0010) begin errors++; $display("FAIL halt_accept got %b/%h want 1111/0010", stage_valid, out_data); end
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %b want 0", in_ready); end
        vectors++;
        halt_req = 1'b0; in_data = 16'h0050;
        for (int c = 0; c < 3; c++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== exp_out[c] || stage_valid !== exp_sv[c]) begin
                errors++; $display("FAIL halt_drain%0d got %b/%h/%b want 1/%h/%b", c, out_valid, out_data, stage_valid, exp_out[c], exp_sv[c]);
            end
            vectors++;
        end
        step();
        if (stage_valid !== 4'b0000 || halted !== 1'b0) begin errors++; $display("FAIL halt_empty got %b/%b want 0000/0", stage_valid, halted); end
        vectors++;
        step();
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_done got %b want 1", halted); end
        vectors++;
        halt_req = 1'b1; step(); step();
        if (halted !== 1'b1 || stage_valid !== 4'b0000 || in_ready !== 1'b0) begin
            errors++; $display("FAIL halt_sticky got %b/%b/%b want 1/0000/0", halted, stage_valid, in_ready);
        end
        vectors++;
        halt_req = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    endtask

    task automatic test_reset_mid_drain();
        rst = 1'b1; #1; rst = 1'b0; #1;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmd_unhalt got %b/%b want 0/1", halted, in_ready); end
        vectors++;
        in_valid = 1'b1;
        in_data = 16'h0001; step();
        in_data = 16'h0002; step();
        in_data = 16'h0003; step();
        in_valid = 1'b0; in_data = 16'h0; halt_req = 1'b1; step();
        halt_req = 1'b0;
        if (occupancy !== 3'd3 || stage_valid !== 4'b1110 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rmd_setup got %0d/%b/%b want 3/1110/0", occupancy, stage_valid, in_ready);
        end
        vectors++;
        #2; rst = 1'b1; #1;
        if (stage_valid !== 4'b0000 || occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
            errors++; $display("FAIL rmd_clear got %b/%0d/%b/%h want 0000/0/0/0000", stage_valid, occupancy, out_valid, out_data);
        end
        vectors++;
        if (in_ready !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rmd_state got %b/%b want 1/0", in_ready, halted); end
        vectors++;
        #1; rst = 1'b0;
        in_valid = 1'b1; in_data = 16'hBEEF; step();
        if (stage_valid !== 4'b0001 || occupancy !== 3'd1) begin errors++; $display("FAIL rmd_accept got %b/%0d want 0001/1", stage_valid, occupancy); end
        vectors++;
        in_valid = 1'b0; in_data = 16'h0;
        step(); step(); step();
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin errors++; $display("FAIL rmd_out got %b/%h want 1/beef", out_valid, out_data); end
        vectors++;
        step();
    endtask

    task automatic test_depth1();
        in_valid1 = 1'b1; in_data1 = 8'hA5; step();
        if (out_valid1 !== 1'b1 || out_data1 !== 8'hA5 || occupancy1 !== 1'b1) begin
            errors++; $display("FAIL d1_accept got %b/%h/%b want 1/a5/1", out_valid1, out_data1, occupancy1);
        end
        vectors++;
        in_data1 = 8'h5A; flush_mask1 = 1'b1; step();
        if (out_valid1 !== 1'b0 || out_data1 !== 8'h00 || occupancy1 !== 1'b0) begin
            errors++; $display("FAIL d1_flush got %b/%h/%b want 0/00/0", out_valid1, out_data1, occupancy1);
        end
        vectors++;
        flush_mask1 = 1'b0; in_data1 = 8'h3C; step();
        if (out_valid1 !== 1'b1 || out_data1 !== 8'h3C) begin errors++; $display("FAIL d1_next got %b/%h want 1/3c", out_valid1, out_data1); end
        vectors++;
        in_valid1 = 1'b0; in_data1 = 8'h0; step();
        if (out_valid1 !== 1'b0 || stage_valid1 !== 1'b0) begin errors++; $display("FAIL d1_bubble got %b/%b want 0/0", out_valid1, stage_valid1); end
        vectors++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; stall = 1'b0; halt_req = 1'b0; flush_mask = 4'b0;
        in_valid1 = 1'b0; in_data1 = 8'h0; stall1 = 1'b0; halt_req1 = 1'b0; flush_mask1 = 1'b0;
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_halt();
        test_reset_mid_drain();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
